frame_dispatcher: RTL
=====================

# frame_dispatcher

Downstream consumer of the all-cores-done `interrupt` produced by the videocard interrupt controller. It splits each frame into tiles, hands one tile per round to each of `CORE_NUM` cores (start pulse plus base address), and advances to the next round on every `interrupt`. After the last round it waits for display vsync, swaps the double-buffer index and starts the next frame.

## Interface
- `CORE_NUM`, 4, number of render cores; matches the interrupt controller's `CORE_NUM`.
- `ADDR_WIDTH`, 16, width of each tile base address (words).
- `TILE_WORDS`, 1024, words per tile.
- `ROUNDS`, 4, dispatch rounds per frame; frame size `FRAME_WORDS = CORE_NUM*ROUNDS*TILE_WORDS`.

Ports:
- `clk` in 1, single clock; all logic on rising edge.
- `reset` in 1, synchronous, active-high.
- `enable` in 1, level; permits rendering of frames.
- `interrupt` in 1, all-cores-done pulse from the interrupt controller.
- `vsync` in 1, display vertical-blank pulse, at least one cycle wide.
- `core_start` out `CORE_NUM`, one-cycle start pulse per core.
- `core_base` out `CORE_NUM*ADDR_WIDTH`, tile base for core i in bits `[i*ADDR_WIDTH +: ADDR_WIDTH]`.
- `buffer_select` out 1, buffer being rendered; display reads the other.
- `frame_done` out 1, one-cycle pulse on buffer swap.
- `frame_count` out 8, completed frames, wraps 255 -> 0.
- `busy` out 1, high whenever state is not IDLE.

## Operation
- States: IDLE, DISPATCH, WAIT_DONE, WAIT_VSYNC, SWAP. Internal `round` counter, 0..`ROUNDS-1`.
- IDLE: `enable`=1 -> DISPATCH.
- DISPATCH (exactly one cycle): `core_start` = all ones, `core_base` loaded; -> WAIT_DONE.
- WAIT_DONE: `interrupt`=1 and `round`<`ROUNDS-1` -> `round`+1, DISPATCH. `interrupt`=1 and `round`=`ROUNDS-1` -> `round`<=0, WAIT_VSYNC.
- WAIT_VSYNC: `vsync`=1 -> SWAP.
- SWAP (one cycle): `buffer_select` toggles, `frame_done`=1, `frame_count`+1. Then `enable`=1 -> DISPATCH, else IDLE.
- Base address for core i: `buffer_select*FRAME_WORDS + (round*CORE_NUM + i)*TILE_WORDS`, computed at full precision and truncated to `ADDR_WIDTH` (modulo 2^ADDR_WIDTH).
- `core_base` is registered on entry to DISPATCH and held stable until the next DISPATCH, including through IDLE.
- `interrupt` is honoured only in WAIT_DONE; in any other state it is ignored and not remembered.
- `vsync` is honoured only in WAIT_VSYNC; a vsync coinciding with the final interrupt is missed, and the block waits for the next one.
- `enable` deassertion mid-frame does not abort; it is checked only in IDLE and SWAP, so the current frame always completes.

## Timing
- Reset: state IDLE, `round`=0, all outputs 0 (`core_start`, `core_base`, `buffer_select`, `frame_done`, `frame_count`, `busy`).
- Reset asserted mid-operation: next edge returns to reset values; cores are not notified and in-flight work is abandoned.
- All outputs are registered. `enable` sampled high at edge n gives `core_start` and `busy` high from edge n+1; `core_start` falls at n+2.
- The interrupt controller drives `interrupt` on the falling edge, one full cycle wide, so exactly one rising-edge sample sees it.
- `interrupt` sampled at edge n in WAIT_DONE (not last round) gives the next `core_start` at edge n+1.
- `vsync` sampled at edge n in WAIT_VSYNC gives SWAP at n+1: `frame_done`=1 and `buffer_select` toggled for that cycle.
- With `enable` held high, `core_start` for the next frame comes at n+2.
- Minimum frame period: `ROUNDS`*2 + 2 cycles plus vsync wait.

## Test plan
- Reset then `enable`=1: `core_start` goes 4'b1111 for exactly one cycle, one cycle after enable; `core_base` = {0x0C00,0x0800,0x0400,0x0000} (core3..core0); `busy`=1.
- Second interrupt of frame 0: round 2 -> core 2 base 0x2800; third interrupt: core 2 base 0x3800 (round 3 = 14*1024).
- Fourth interrupt, then vsync 5 cycles later: no `core_start` meanwhile; `frame_done` one cycle; `buffer_select`=1; `frame_count`=1; next `core_start` with core 0 base 0x4000, core 3 base 0x4C00.
- Interrupt during DISPATCH or WAIT_VSYNC, and vsync during WAIT_DONE: ignored. Round and state are unchanged, with no extra `core_start`.
- `enable` dropped in round 1: the frame completes through SWAP, then IDLE with `busy`=0 and `core_base` held; `enable` reasserted -> DISPATCH with `buffer_select`=1 bases.
- `reset` pulsed in WAIT_DONE round 2: all outputs return to 0 and the state to IDLE on the next edge. 256 frames: `frame_count` wraps to 0, and `buffer_select` ends at 0.

Source files
------------

// File: rtl/frame_dispatcher.sv
// Frame dispatcher: hands one tile per round to each render core and advances
// rounds on the all-cores-done interrupt, swapping the double buffer on vsync.
module frame_dispatcher #(
  parameter int CORE_NUM   = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int TILE_WORDS = 1024,
  parameter int ROUNDS     = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           interrupt,
  input  logic                           vsync,
  output logic [CORE_NUM-1:0]            core_start,
  output logic [CORE_NUM*ADDR_WIDTH-1:0] core_base,
  output logic                           buffer_select,
  output logic                           frame_done,
  output logic [7:0]                     frame_count,
  output logic                           busy
);

  localparam int FRAME_WORDS = CORE_NUM * ROUNDS * TILE_WORDS;
  localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS - 1);

  typedef enum logic [2:0] {IDLE, DISPATCH, WAIT_DONE, WAIT_VSYNC, SWAP} state_t;

  state_t                           state, next_state;
  logic [RW-1:0]                    round, next_round;
  logic [CORE_NUM*ADDR_WIDTH-1:0]   next_base;

  // Wide intermediate, wrapped to the address width on return.
  function automatic logic [ADDR_WIDTH-1:0] tile_base(input logic sel,
                                                      input logic [RW-1:0] rnd,
                                                      input int core);
    return ADDR_WIDTH'(64'(sel) * 64'(FRAME_WORDS) +
                       (64'(rnd) * 64'(CORE_NUM) + 64'(core)) * 64'(TILE_WORDS));
  endfunction

  always_comb begin
    next_state = state;
    next_round = round;
    case (state)
      IDLE:       if (enable) next_state = DISPATCH;
      DISPATCH:   next_state = WAIT_DONE;
      WAIT_DONE: begin
        if (interrupt) begin
          if (round == LAST_ROUND) begin
            next_round = '0;
            next_state = WAIT_VSYNC;
          end else begin
            next_round = round + RW'(1);
            next_state = DISPATCH;
          end
        end
      end
      WAIT_VSYNC: if (vsync) next_state = SWAP;
      SWAP:       next_state = enable ? DISPATCH : IDLE;
      default:    next_state = IDLE;
    endcase
  end

  // Bases use the current buffer index: by the time SWAP leads into DISPATCH
  // the buffer has already toggled, so a new frame lands in the fresh buffer.
  always_comb begin
    next_base = '0;
    for (int i = 0; i < CORE_NUM; i++)
      next_base[i*ADDR_WIDTH +: ADDR_WIDTH] = tile_base(buffer_select, next_round, i);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      round         <= '0;
      core_start    <= '0;
      core_base     <= '0;
      buffer_select <= 1'b0;
      frame_done    <= 1'b0;
      frame_count   <= 8'd0;
      busy          <= 1'b0;
    end else begin
      state      <= next_state;
      round      <= next_round;
      core_start <= {CORE_NUM{next_state == DISPATCH}};
      frame_done <= (next_state == SWAP);
      busy       <= (next_state != IDLE);
      if (next_state == DISPATCH)
        core_base <= next_base;
      if (next_state == SWAP) begin
        buffer_select <= ~buffer_select;
        frame_count   <= frame_count + 8'd1;
      end
    end
  end

endmodule
